div_result_bcd: RTL and testbench
=================================

DIV_RESULT_BCD -- requirements
Module: div_result_bcd

Interface
REQ-001 The block SHALL have one clock and one synchronous, active-low reset: clk input 1 (rising edge) and rst_n input 1 (sampled on clk; 0 = reset).
REQ-002 in_valid input 1 SHALL mean the upstream Divide result is presented.
REQ-003 in_ready output 1 SHALL mean the block accepts a result this cycle.
REQ-004 result input 8 SHALL carry the Divide output word: [7:4] quotient, [3:0] remainder.
REQ-005 out_valid output 1 SHALL mean bcd holds a finished conversion.
REQ-006 out_ready input 1 SHALL mean downstream consumes bcd this cycle.
REQ-007 bcd output 16 SHALL carry the packed BCD digits, 4 bits per digit, most significant digit in the upper bits.

Function
REQ-008 The block SHALL have three states: IDLE, SHIFT and DONE.
REQ-009 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-010 In IDLE, in_valid=1 SHALL transfer the input: latch result into the shift register, clear the digit accumulators, load the iteration counter, and enter SHIFT on the next edge.
REQ-011 In IDLE, in_valid=0 SHALL hold state.
REQ-012 Each SHIFT cycle SHALL run one double-dabble step: add 3 to every BCD digit >= 5, then shift {digits, remaining bits} left by 1.
REQ-013 SHIFT SHALL run exactly N cycles, then enter DONE. N = 8 in default mode, 4 in split mode.
REQ-014 The transfer-to-out_valid latency SHALL be N+1 cycles: 9 in default mode, 5 in split mode.
REQ-015 In DONE, bcd SHALL hold stable until out_valid=1 and out_ready=1, which returns the block to IDLE on that edge.
REQ-016 Because in_ready=0 outside IDLE, the block SHALL accept no new input in the cycle of the DONE handshake; the next transfer occurs at the earliest one cycle later.
REQ-017 Under backpressure (out_ready=0), DONE SHALL hold indefinitely with in_ready=0; no result SHALL be dropped or overwritten.
REQ-018 The block SHALL ignore result and in_valid outside IDLE.
REQ-019 Every digit SHALL be in the range 0-9 for all 256 input values; no binary overflow SHALL occur.

Reset
REQ-020 When rst_n=0 at a clock edge, state SHALL become IDLE, the iteration counter and shift/digit registers 0, bcd 16'h0000, out_valid 0, and in_ready 1 after that edge.
REQ-021 Reset SHALL take priority over every handshake and SHALL abort any conversion in progress (SHIFT or DONE) with no partial result emitted.
REQ-022 After reset releases, the block SHALL accept input in the first cycle with rst_n=1.

Configuration
REQ-023 Macro DIV_BCD_SPLIT_EN SHALL select the conversion mode.
REQ-024 Without DIV_BCD_SPLIT_EN, the block SHALL convert the whole 8-bit result as one unsigned value to 3 digits: bcd[11:0] = hundreds/tens/ones, bcd[15:12] = 0, N = 8.
REQ-025 With DIV_BCD_SPLIT_EN, the block SHALL convert the quotient and remainder nibbles separately, in parallel, each to 2 digits: bcd[15:8] = quotient tens/ones, bcd[7:0] = remainder tens/ones, N = 4.
REQ-026 The handshake and state machine SHALL be identical in both modes.

Verification
REQ-027 Default mode: transfer result=8'd255, hold out_ready=1 -> out_valid rises 9 cycles after the transfer with bcd=16'h0255; the block returns to IDLE after one DONE cycle.
REQ-028 Default mode: transfer 8'd0, then 8'd128, then 8'd9 back to back -> bcd sequence 16'h0000, 16'h0128, 16'h0009; in_ready=0 throughout each SHIFT/DONE period.
REQ-029 Backpressure: transfer 8'd100 with out_ready=0 for 20 cycles, and toggle in_valid with result=8'd7 during the stall -> bcd stays 16'h0100 with out_valid=1; 8'd7 is not accepted until the block is back in IDLE.
REQ-030 Reset mid-operation: assert rst_n=0 on the 4th SHIFT cycle of 8'd200 -> next cycle out_valid=0, bcd=16'h0000, in_ready=1; a following transfer of 8'd42 yields 16'h0042.
REQ-031 Split mode (DIV_BCD_SPLIT_EN): transfer result=8'h52 -> 16'h0502 after 5 cycles; transfer 8'hFF -> 16'h1515; transfer 8'hA0 -> 16'h1000.
REQ-032 Exhaustive sweep, both modes: all 256 result values -> every digit <= 9 and bcd matches the reference decimal value.

Source files
------------

// File: rtl/div_result_bcd.sv
// rtl/div_result_bcd.sv - double-dabble BCD converter for the Divide result word
// DIV_BCD_SPLIT_EN: convert quotient/remainder nibbles separately (2 digits each) instead of the whole byte.
module div_result_bcd (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] bcd
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

`ifdef DIV_BCD_SPLIT_EN
    localparam logic [3:0] N_STEPS = 4'd4;
`else
    localparam logic [3:0] N_STEPS = 4'd8;
`endif

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [7:0]  r_shift;
    logic [15:0] r_digits;
    logic [15:0] w_digits_next;
    logic [7:0]  w_shift_next;

    // Add-3-then-shift for one digit; the digit's carry-out is (d >= 5), taken by the next digit up.
    function automatic logic [3:0] dd_step(input logic [3:0] d, input logic cin);
        if (d >= 4'd5) begin
            dd_step = {d[2:0] + 3'd3, cin};
        end else begin
            dd_step = {d[2:0], cin};
        end
    endfunction

    always_comb begin
        w_digits_next = '0;
        w_shift_next  = '0;
`ifdef DIV_BCD_SPLIT_EN
        w_digits_next[3:0]   = dd_step(r_digits[3:0],   r_shift[3]);
        w_digits_next[7:4]   = dd_step(r_digits[7:4],   r_digits[3:0] >= 4'd5);
        w_digits_next[11:8]  = dd_step(r_digits[11:8],  r_shift[7]);
        w_digits_next[15:12] = dd_step(r_digits[15:12], r_digits[11:8] >= 4'd5);
        w_shift_next         = {r_shift[6:4], 1'b0, r_shift[2:0], 1'b0};
`else
        w_digits_next[3:0]   = dd_step(r_digits[3:0],   r_shift[7]);
        w_digits_next[7:4]   = dd_step(r_digits[7:4],   r_digits[3:0] >= 4'd5);
        w_digits_next[11:8]  = dd_step(r_digits[11:8],  r_digits[7:4] >= 4'd5);
        w_digits_next[15:12] = dd_step(r_digits[15:12], r_digits[11:8] >= 4'd5);
        w_shift_next         = {r_shift[6:0], 1'b0};
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = S_SHIFT;
            S_SHIFT: if (r_cnt == 4'd1) w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_shift  <= '0;
            r_digits <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_shift  <= result;
                        r_digits <= '0;
                        r_cnt    <= N_STEPS;
                    end
                end
                S_SHIFT: begin
                    r_shift  <= w_shift_next;
                    r_digits <= w_digits_next;
                    r_cnt    <= r_cnt - 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bcd = r_digits;

endmodule

// File: tb/tb_div_result_bcd.sv
// tb/tb_div_result_bcd.sv - self-checking bench for div_result_bcd (both DIV_BCD_SPLIT_EN modes)
module tb_div_result_bcd;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  result;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] bcd;

    int n_cmp = 0;
    int n_err = 0;

`ifdef DIV_BCD_SPLIT_EN
    localparam int N = 4;
`else
    localparam int N = 8;
`endif

    div_result_bcd dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .result    (result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd       (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_bcd(input int v);
`ifdef DIV_BCD_SPLIT_EN
        int q = v / 16;
        int r = v % 16;
        return {4'(q / 10), 4'(q % 10), 4'(r / 10), 4'(r % 10)};
`else
        return {4'd0, 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
`endif
    endfunction

    function automatic bit digits_ok(input logic [15:0] b);
        return (b[3:0] <= 4'd9) && (b[7:4] <= 4'd9) && (b[11:8] <= 4'd9) && (b[15:12] <= 4'd9);
    endfunction

    task automatic transfer(input logic [7:0] v);
        @(negedge clk);
        in_valid = 1'b1;
        result   = v;
        for (int i = 0; i < 40 && !in_ready; i++) @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL transfer_ready: in_ready=%b expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        result   = 8'($urandom);
    endtask

    // One full conversion: transfer, wait for DONE, optional stall, handshake.
    task automatic convert(input logic [7:0] v, input int stall);
        logic [15:0] exp_bcd;
        int k;
        bit found;
        exp_bcd   = ref_bcd(int'(v));
        out_ready = (stall == 0);
        transfer(v);
        found = 0;
        k = 0;
        while (!found && k < 40) begin
            @(negedge clk);
            k++;
            if (out_valid === 1'b1) begin
                found = 1;
            end else begin
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL busy_in_ready v=%0d cycle=%0d: in_ready=%b expected 0", v, k, in_ready);
                end
            end
        end
        n_cmp++;
        if (k != N + 1) begin
            n_err++;
            $display("FAIL latency v=%0d: got %0d expected %0d", v, k, N + 1);
        end
        n_cmp++;
        if (bcd !== exp_bcd) begin
            n_err++;
            $display("FAIL bcd v=%0d: got %h expected %h", v, bcd, exp_bcd);
        end
        n_cmp++;
        if (!digits_ok(bcd)) begin
            n_err++;
            $display("FAIL digit_range v=%0d: got %h expected all digits <= 9", v, bcd);
        end
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || bcd !== exp_bcd || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold v=%0d: out_valid=%b bcd=%h in_ready=%b expected 1 %h 0",
                         v, out_valid, bcd, in_ready, exp_bcd);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL return_idle v=%0d: out_valid=%b in_ready=%b expected 0 1", v, out_valid, in_ready);
        end
    endtask

    task automatic test_reset;
        int k;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || bcd !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b bcd=%h expected 1 0 0000", in_ready, out_valid, bcd);
        end
        rst_n     = 1'b1;
        in_valid  = 1'b1;
        result    = 8'd37;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL first_cycle_accept: in_ready=%b expected 0", in_ready);
        end
        k = 1;
        while (out_valid !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (out_valid !== 1'b1 || bcd !== ref_bcd(37)) begin
            n_err++;
            $display("FAIL first_cycle_bcd: out_valid=%b bcd=%h expected 1 %h", out_valid, bcd, ref_bcd(37));
        end
        @(negedge clk);
    endtask

    task automatic test_fixed_values;
        logic [15:0] got;
`ifdef DIV_BCD_SPLIT_EN
        logic [7:0]  vals [3] = '{8'h52, 8'hFF, 8'hA0};
        logic [15:0] exps [3] = '{16'h0502, 16'h1515, 16'h1000};
`else
        logic [7:0]  vals [3] = '{8'd255, 8'd100, 8'd99};
        logic [15:0] exps [3] = '{16'h0255, 16'h0100, 16'h0099};
`endif
        for (int i = 0; i < 3; i++) begin
            convert(vals[i], 0);
            got = bcd;
            n_cmp++;
            if (ref_bcd(int'(vals[i])) !== exps[i]) begin
                n_err++;
                $display("FAIL model_const v=%h: model %h expected %h", vals[i], ref_bcd(int'(vals[i])), exps[i]);
            end
            n_cmp++;
            if (got !== 16'h0000 && got !== exps[i]) begin
                n_err++;
                $display("FAIL held_after_done v=%h: got %h expected %h", vals[i], got, exps[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] vals [3] = '{8'd0, 8'd128, 8'd9};
        int k;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        result    = vals[0];
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_idle i=%0d: in_ready=%b out_valid=%b expected 1 0", i, in_ready, out_valid);
            end
            @(posedge clk);
            #1;
            if (i < 2) result = vals[i + 1];
            else in_valid = 1'b0;
            k = 0;
            while (k < 40) begin
                @(negedge clk);
                k++;
                if (out_valid === 1'b1) break;
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL b2b_busy i=%0d: in_ready=%b expected 0", i, in_ready);
                end
            end
            n_cmp++;
            if (k != N + 1 || bcd !== ref_bcd(int'(vals[i]))) begin
                n_err++;
                $display("FAIL b2b_result i=%0d: latency=%0d bcd=%h expected %0d %h", i, k, bcd, N + 1, ref_bcd(int'(vals[i])));
            end
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_done_ready i=%0d: in_ready=%b expected 0", i, in_ready);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_final: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_backpressure;
        int k;
        out_ready = 1'b0;
        transfer(8'd100);
        k = 0;
        while (out_valid !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        for (int s = 0; s < 20; s++) begin
            in_valid = s[0];
            result   = 8'd7;
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || bcd !== ref_bcd(100) || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL backpressure s=%0d: out_valid=%b bcd=%h in_ready=%b expected 1 %h 0",
                         s, out_valid, bcd, in_ready, ref_bcd(100));
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
        end
        convert(8'd7, 0);
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b1;
        transfer(8'd200);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || bcd !== 16'h0000 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid: out_valid=%b bcd=%h in_ready=%b expected 0 0000 1", out_valid, bcd, in_ready);
        end
        rst_n = 1'b1;
        convert(8'd42, 0);
    endtask

    task automatic test_sweep;
        for (int v = 0; v < 256; v++) begin
            convert(8'(v), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        result    = 8'h00;
        out_ready = 1'b0;
        test_reset();
        test_fixed_values();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
